// File: rtl/conv_result_collector.sv
// Output-side collector for the convolver datapath: tags valid-window pixels,
// aligns the tag with add_result, stores results in raster order and streams them.
module conv_result_collector #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned IMAGE_SIZE  = 28,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1,
    parameter int unsigned ADDR_WIDTH  = $clog2(OUT_SIZE * OUT_SIZE),
    parameter int unsigned CNT_WIDTH   = $clog2(IMAGE_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] add_result,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  frame_done,
    output logic                  busy,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = OUT_SIZE * OUT_SIZE;
    localparam int unsigned KM1   = KERNEL_SIZE - 1;
    localparam int unsigned IMAX  = IMAGE_SIZE - 1;

    logic [CNT_WIDTH-1:0]  r_in_row;
    logic [CNT_WIDTH-1:0]  r_in_col;
    logic                  w_col_end;
    logic                  w_row_end;
    logic [CNT_WIDTH-1:0]  w_out_row;
    logic [CNT_WIDTH-1:0]  w_out_col;
    logic                  w_win;
    logic                  w_tag_last;
    logic [ADDR_WIDTH-1:0] w_tag_addr;

    logic                  r_dl_vld  [LATENCY];
    logic                  r_dl_last [LATENCY];
    logic [ADDR_WIDTH-1:0] r_dl_addr [LATENCY];
    logic                  w_dl_vld;
    logic                  w_dl_last;
    logic [ADDR_WIDTH-1:0] w_dl_addr;
    logic                  w_done;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_col_end = (r_in_col == CNT_WIDTH'(IMAX));
    assign w_row_end = (r_in_row == CNT_WIDTH'(IMAX));

    // Raster position of the next accepted pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_row <= '0;
            r_in_col <= '0;
        end else if (write) begin
            if (w_col_end) begin
                r_in_col <= '0;
                r_in_row <= w_row_end ? '0 : r_in_row + CNT_WIDTH'(1);
            end else begin
                r_in_col <= r_in_col + CNT_WIDTH'(1);
            end
        end
    end

    // Window tag for the pixel entering this cycle; address only meaningful when w_win
    assign w_win      = write && (r_in_row >= CNT_WIDTH'(KM1)) && (r_in_col >= CNT_WIDTH'(KM1));
    assign w_tag_last = write && w_col_end && w_row_end;
    assign w_out_row  = r_in_row - CNT_WIDTH'(KM1);
    assign w_out_col  = r_in_col - CNT_WIDTH'(KM1);
    assign w_tag_addr = ADDR_WIDTH'(w_out_row) * ADDR_WIDTH'(OUT_SIZE) + ADDR_WIDTH'(w_out_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_dl_vld[i] <= 1'b0;
            end
        end else begin
            r_dl_vld[0] <= w_win;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
            end
        end
    end

    // Payload side of the delay line; qualified by the valid bits
    always_ff @(posedge clk) begin
        r_dl_addr[0] <= w_tag_addr;
        r_dl_last[0] <= w_tag_last;
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_dl_addr[i] <= r_dl_addr[i-1];
            r_dl_last[i] <= r_dl_last[i-1];
        end
    end

    assign w_dl_vld  = r_dl_vld[LATENCY-1];
    assign w_dl_last = r_dl_last[LATENCY-1];
    assign w_dl_addr = r_dl_addr[LATENCY-1];
    assign w_done    = w_dl_vld && w_dl_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid  <= w_dl_vld;
            frame_done <= w_done;
            if (w_dl_vld) begin
                out_data <= add_result;
                out_addr <= w_dl_addr;
            end
            // A write in the frame_done cycle starts the next frame
            if (write) begin
                busy <= 1'b1;
            end else if (w_done) begin
                busy <= 1'b0;
            end
        end
    end

    // Feature-map buffer: contents survive reset
    always_ff @(posedge clk) begin
        if (w_dl_vld && !reset) begin
            r_mem[w_dl_addr] <= add_result;
        end
    end

    // Registered read-first port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (rd_addr < ADDR_WIDTH'(DEPTH)) ? r_mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_conv_result_collector.sv
// Randomized bench for conv_result_collector: a scoreboard of expected output
// pulses derived from raster positions, plus a buffer model for the read port.
module tb_conv_result_collector;

    localparam int DW   = 16;
    localparam int KS   = 5;
    localparam int IS   = 28;
    localparam int LAT  = 3;
    localparam int OS   = IS - KS + 1;
    localparam int NPIX = IS * IS;
    localparam int NOUT = OS * OS;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [DW-1:0] add_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          frame_done;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    conv_result_collector #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(KS),
        .IMAGE_SIZE (IS),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .add_result(add_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .frame_done(frame_done),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   data_at[int];
    int   mem_m[NOUT];
    int   cyc       = 0;
    int   pix       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_valid   = 0;
    int   n_done    = 0;
    bit   busy_m    = 1'b0;
    int   last_data = 0;
    int   last_addr = 0;
    int   rd_m      = 0;
    bit   probed    = 1'b0;

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs
    task automatic step(input bit rst, input bit wr, input int dval, input bit rd, input int ra);
        exp_t e;
        bit   hit;
        bit   done;
        int   r;
        int   c;
        reset   = rst;
        write   = wr;
        rd_en   = rd;
        rd_addr = AW'(ra);
        if (data_at.exists(cyc)) begin
            add_result = DW'(data_at[cyc]);
            data_at.delete(cyc);
        end else begin
            add_result = DW'($urandom);
        end
        if (wr && !rst) begin
            r = pix / IS;
            c = pix % IS;
            if (r >= KS - 1 && c >= KS - 1) begin
                e.cyc  = cyc + LAT;
                e.addr = (r - KS + 1) * OS + (c - KS + 1);
                e.data = dval & 16'hFFFF;
                e.last = (pix == NPIX - 1);
                exp_q.push_back(e);
                data_at[cyc + LAT] = e.data;
            end
            pix = (pix + 1) % NPIX;
        end
        @(posedge clk);
        #1;
        hit  = 1'b0;
        done = 1'b0;
        if (rst) begin
            exp_q.delete();
            pix       = 0;
            busy_m    = 1'b0;
            last_data = 0;
            last_addr = 0;
            rd_m      = 0;
        end else begin
            if (rd) rd_m = mem_m[ra];
            hit = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (hit) begin
                e = exp_q.pop_front();
                mem_m[e.addr] = e.data;
                last_data     = e.data;
                last_addr     = e.addr;
                done          = e.last;
            end
            busy_m = wr ? 1'b1 : (done ? 1'b0 : busy_m);
        end
        check("out_valid", 32'(out_valid), 32'(hit));
        check("frame_done", 32'(frame_done), 32'(done));
        check("out_data", 32'(out_data), last_data);
        check("out_addr", 32'(out_addr), last_addr);
        check("busy", 32'(busy), 32'(busy_m));
        check("rd_data", 32'(rd_data), rd_m);
        if (out_valid) n_valid++;
        if (frame_done) n_done++;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    // Full frame; probe0 reads addr 0 in the cycle the buffer writes addr 0
    task automatic frame(input int base, input int max_gap, input bit probe0);
        bit rd;
        for (int p = 0; p < NPIX; p++) begin
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            rd = probe0 && (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && (exp_q[0].addr == 0);
            step(1'b0, 1'b1, base + p, rd, 0);
            if (rd) begin
                probed = 1'b1;
                check("rd_first_old", 32'(rd_data), 116);
            end
        end
    endtask

    task automatic read_chk(input int a, input int expv);
        step(1'b0, 1'b0, 0, 1'b1, a);
        check("rd_const", 32'(rd_data), expv);
    endtask

    initial begin
        int mv;
        int md;
        reset      = 1'b1;
        write      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        add_result = '0;
        repeat (3) step(1'b1, 1'b0, 0, 1'b0, 0);

        // Contiguous frame, data = pixel index
        mv = n_valid; md = n_done;
        frame(0, 0, 1'b0);
        idle(LAT + 3);
        check("A_pulses", n_valid - mv, NOUT);
        check("A_done", n_done - md, 1);

        // Same frame with random idle gaps
        mv = n_valid; md = n_done;
        frame(0, 3, 1'b0);
        idle(LAT + 3);
        check("B_pulses", n_valid - mv, NOUT);
        check("B_done", n_done - md, 1);

        read_chk(0, 116);
        read_chk(23, 139);
        read_chk(24, 144);
        read_chk(575, 783);

        // Abort mid-frame; write held high through reset must be ignored
        for (int p = 0; p < 300; p++) step(1'b0, 1'b1, 5000 + p, 1'b0, 0);
        step(1'b1, 1'b1, 0, 1'b0, 0);
        step(1'b1, 1'b1, 0, 1'b0, 0);
        read_chk(0, 5116);
        mv = n_valid; md = n_done;
        frame(2000, 0, 1'b0);
        idle(LAT + 3);
        check("R_pulses", n_valid - mv, NOUT);
        check("R_done", n_done - md, 1);
        read_chk(0, 2116);

        // Back-to-back frames with a read-first probe in the second
        mv = n_valid; md = n_done;
        frame(0, 0, 1'b0);
        frame(1000, 0, 1'b1);
        idle(LAT + 3);
        check("BB_pulses", n_valid - mv, 2 * NOUT);
        check("BB_done", n_done - md, 2);
        check("probe_hit", 32'(probed), 1);
        read_chk(0, 1116);
        read_chk(575, 1783);

        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Consumer at the output end of the convolver `datapath`. It receives the same `write` strobe that feeds raster-order pixels into the datapath. It tracks which input pixel completes a valid KERNEL_SIZE×KERNEL_SIZE window and aligns that flag with `add_result` through a fixed-latency delay line. It keeps only the valid-window results, writes them into an internal feature-map buffer in output raster order, and exposes them on a streaming port and a registered read port.

## Interface
- DATA_WIDTH, 16, width of `add_result` and stored results (signed fixed point, format passed through untouched)
- KERNEL_SIZE, 5, convolution window edge
- IMAGE_SIZE, 28, input image edge
- LATENCY, 3, cycles from a `write` strobe to the matching `add_result` (range 1–8)
- Derived: OUT_SIZE = IMAGE_SIZE−KERNEL_SIZE+1 (24); ADDR_WIDTH = clog2(OUT_SIZE²) (10); CNT_WIDTH = clog2(IMAGE_SIZE) (5)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- write  in  1  pixel accepted by datapath this cycle (same strobe as datapath `write`)
- add_result  in  DATA_WIDTH  datapath result, signed
- out_valid  out  1  valid-window result emitted this cycle
- out_data  out  DATA_WIDTH  result emitted with `out_valid`
- out_addr  out  ADDR_WIDTH  output raster index of `out_data`
- frame_done  out  1  one-cycle pulse with the last (OUT_SIZE²−1) result of a frame
- busy  out  1  high from first `write` of a frame until `frame_done`
- rd_en  in  1  buffer read request
- rd_addr  in  ADDR_WIDTH  buffer read index
- rd_data  out  DATA_WIDTH  registered read data, valid the cycle after `rd_en`

## Operation
- Input counters `in_row`, `in_col` advance only on `write`.
  - `in_col` wraps at IMAGE_SIZE−1 and increments `in_row`.
  - At (IMAGE_SIZE−1, IMAGE_SIZE−1) both wrap to 0, ready for the next frame.
- Window-valid flag on a `write` at position (r,c): `win = (r ≥ KERNEL_SIZE−1) && (c ≥ KERNEL_SIZE−1)`.
  - Tag address = (r−KERNEL_SIZE+1)·OUT_SIZE + (c−KERNEL_SIZE+1).
  - Tag last = (r == c == IMAGE_SIZE−1).
- Delay line is LATENCY stages of {win∧write, addr, last}.
  - Shifts every cycle, independent of `write`.
  - Idle cycles insert zero-valid bubbles.
- Delay-line output valid (stage LATENCY) does the following in the same edge:
  - writes `add_result` to the buffer at the tag address;
  - registers out_valid=1, out_data=add_result, out_addr=addr;
  - registers frame_done=last.
- Otherwise out_valid=0 and frame_done=0; out_data and out_addr hold their previous values.
- busy:
  - set on any `write` while busy=0;
  - cleared on the cycle frame_done is registered.
  - A `write` in that same cycle re-sets busy, so the new frame wins.
- Buffer is OUT_SIZE² × DATA_WIDTH, single write port and single read port.
  - Read is registered: `rd_data` updates only when rd_en=1 and holds otherwise.
  - Same-cycle write and read to one address returns old data (read-first).
- No arithmetic on data. Addresses are unsigned. Counters never exceed IMAGE_SIZE−1.

## Timing
- Reset values: out_valid=0, out_data=0, out_addr=0, frame_done=0, busy=0, rd_data=0, counters=0, delay line valid bits=0.
- Buffer contents are not reset.
- Reset mid-frame discards in-flight delay-line entries. The next `write` after reset is treated as pixel (0,0).
- Results stored before reset stay readable.
- Latency: `write` of pixel p at edge t gives `add_result` sampled at edge t+LATENCY and out_valid high during the cycle after edge t+LATENCY.
- First valid result of a frame comes from pixel index (KERNEL_SIZE−1)·IMAGE_SIZE + KERNEL_SIZE−1 = 116.
- Last valid result comes from pixel index 783.
- Pixels with c < KERNEL_SIZE−1 (row wrap-around) or r < KERNEL_SIZE−1 never produce out_valid.
- Back-to-back frames need no idle cycles. Delay-line entries of frame N drain while frame N+1 pixels enter.
- `write` during reset is ignored.

## Test plan
- Reset then 784 consecutive writes, add_result driven = delayed pixel index:
  - exactly 576 out_valid pulses;
  - first pulse has out_addr=0, out_data=116;
  - pulse k has out_addr=k;
  - last pulse has out_addr=575, out_data=783, frame_done=1;
  - busy falls the next cycle.
- Same frame with a random 0–3 idle cycles between writes: identical address/data sequence, out_valid always exactly LATENCY cycles after the completing write.
- After the frame, rd_en with rd_addr=0, 23, 24, 575: rd_data on the following cycle = 116, 139, 144, 783.
- Assert reset after 300 writes, then send a full frame: no out_valid from the aborted frame after reset; new frame's first out_addr=0 comes from its pixel 116.
- Two frames back-to-back (add_result = index + 1000 on the second):
  - exactly two frame_done pulses;
  - busy stays high across the boundary;
  - second frame's rd_addr=0 reads 1116.
- During the second frame, rd_en at addr 0 in the same cycle the buffer writes addr 0: rd_data=116 (old value); next read of addr 0 returns 1116.
